// File: rtl/read_intr_pkg.sv
// read_intr_pkg: shared state encoding and widths for the read-interrupt receiver.
package read_intr_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    QUALIFY  = 2'b01,
    WAIT_LOW = 2'b10
  } state_t;
  localparam int CNT_W        = 5;
  localparam int GLITCH_CNT_W = 8;
endpackage

// File: rtl/read_intr_sync.sv
// read_intr_sync: 2-flop synchronizer with asynchronous active-low reset.
module read_intr_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 2'b00;
    else ff_q <= {ff_q[0], d_i};
  end
  assign q_o = ff_q[1];
endmodule

// File: rtl/read_intr_receiver.sv
// read_intr_receiver: qualifies stretched read-interrupt pulses into single-cycle events.
// Define READ_INTR_SYNC_EN to pass read_intr_in through a 2-flop synchronizer first.
module read_intr_receiver
  import read_intr_pkg::*;
#(
  parameter int MIN_WIDTH = 8,
  parameter int EVT_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    read_intr_in,
  input  logic                    read_ack,
  input  logic                    overflow_clr,
  output logic                    read_event,
  output logic                    read_pending,
  output logic                    read_overflow,
  output logic [EVT_CNT_W-1:0]    read_event_cnt,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MIN_WIDTH - 1);
  logic s_in;
`ifdef READ_INTR_SYNC_EN
  read_intr_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(read_intr_in), .q_o(s_in));
`else
  assign s_in = read_intr_in;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic evt_q, evt_d, glitch_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    evt_d    = 1'b0;
    glitch_d = 1'b0;
    case (state_q)
      IDLE: if (s_in) begin
        state_d = QUALIFY;
        cnt_d   = CNT_W'(1);
      end
      QUALIFY: if (!s_in) begin
        glitch_d = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else if (cnt_q == LAST) begin
        evt_d   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end else cnt_d = cnt_q + CNT_W'(1);
      WAIT_LOW: if (!s_in) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // an ack coinciding with a new event retires the old one, so no overflow
    pend_d       = evt_d ? 1'b1 : (read_ack ? 1'b0 : pend_q);
    ovf_d        = (evt_d && pend_q && !read_ack) ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    evt_cnt_d    = evt_cnt_q + EVT_CNT_W'(evt_d);
    glitch_cnt_d = glitch_cnt_q + GLITCH_CNT_W'(glitch_d && glitch_cnt_q != '1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      evt_q        <= 1'b0;
      pend_q       <= 1'b0;
      ovf_q        <= 1'b0;
      evt_cnt_q    <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      evt_q        <= evt_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      evt_cnt_q    <= evt_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end
  assign read_event     = evt_q;
  assign read_pending   = pend_q;
  assign read_overflow  = ovf_q;
  assign read_event_cnt = evt_cnt_q;
  assign glitch_cnt     = glitch_cnt_q;
endmodule
